adbg_or1k_bp_xtrig: RTL and testbench
=====================================

ADBG_OR1K_BP_XTRIG -- requirements
Module: adbg_or1k_bp_xtrig

Interface
REQ-001 The block SHALL have parameter NB_CORES, default 4, number of debugged cores.
REQ-002 The block SHALL have cpu_clk_i  input  1  CPU clock; all logic on its rising edge.
REQ-003 The block SHALL have cpu_rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have core_bp_i  input  NB_CORES  per-core breakpoint level from core debug unit.
REQ-005 The block SHALL have core_halted_i  input  NB_CORES  per-core halted acknowledge from core.
REQ-006 The block SHALL have stall_i  input  NB_CORES  stall request from debug status register (its cpu_stall_o).
REQ-007 The block SHALL have xtrig_mask_i  input  NB_CORES  cores belonging to the cross-trigger halt group.
REQ-008 The block SHALL have bp_o  output  NB_CORES  breakpoint pulse to debug status register bp_i.
REQ-009 The block SHALL have halt_req_o  output  NB_CORES  halt request to core.
REQ-010 The block SHALL have cause_o  output  2*NB_CORES  per-core halt cause, 2 bits per core, core i at [2i+1:2i].
REQ-011 The block SHALL have all_halted_o  output  1  every core in HALTED.

Function
REQ-012 Each core SHALL own a 4-state FSM: RUN, HALT_WAIT, HALTED, RESUME_WAIT.
REQ-013 Own bp event for core i SHALL be a rising edge of core_bp_i[i] (registered previous value) while core i is in RUN.
REQ-014 On own bp event in cycle N, bp_o[i] SHALL be 1 for exactly cycle N+1 (registered), and cause_o[i] SHALL load 2'b01.
REQ-015 Cross-trigger event: in a cycle with an own bp event on any core k with xtrig_mask_i[k]=1, every other core j in RUN with xtrig_mask_i[j]=1 and no own event SHALL get a bp_o[j] pulse in the same N+1 cycle and cause 2'b10.
REQ-016 Own event SHALL take priority over cross-trigger cause when both apply in one cycle.
REQ-017 RUN -> HALT_WAIT SHALL occur on the cycle bp_o[i] is asserted, or when stall_i[i]=1 with no bp pulse (cause 2'b11, host stall).
REQ-018 HALT_WAIT -> HALTED SHALL occur when core_halted_i[i]=1.
REQ-019 HALTED -> RESUME_WAIT SHALL occur when stall_i[i]=0 and bp_o[i]=0.
REQ-020 RESUME_WAIT -> RUN SHALL occur when core_halted_i[i]=0; cause_o[i] SHALL clear to 2'b00 on entering RUN.
REQ-021 halt_req_o[i] SHALL be 1 exactly in HALT_WAIT and HALTED (registered from state).
REQ-022 stall_i deassertion during HALT_WAIT SHALL be ignored; core still proceeds to HALTED before resuming.
REQ-023 core_bp_i edges in any state other than RUN SHALL be ignored, produce no bp_o, and not cross-trigger.
REQ-024 core_bp_i held high SHALL produce one event only; a new event requires a low level first.
REQ-025 all_halted_o SHALL be the AND of (state==HALTED) over all cores, registered.
REQ-026 bp_o SHALL be registered so no combinational path exists from stall_i to bp_o.

Reset
REQ-027 On cpu_rstn_i low, all FSMs SHALL enter RUN; bp_o, halt_req_o, cause_o, all_halted_o, edge registers SHALL be 0.
REQ-028 Reset mid-handshake SHALL abandon it; first core_bp_i edge after reset SHALL be detected relative to 0.

Configuration
REQ-029 With macro ADBG_OR1K_XTRIG_EN defined, cross-trigger per REQ-015 SHALL be built.
REQ-030 Without ADBG_OR1K_XTRIG_EN, xtrig_mask_i SHALL be ignored, only own events pulse bp_o, cause 2'b10 SHALL never occur.

Verification
REQ-031 NB_CORES=4, mask=4'b0000, core_bp_i[2] rises cycle 10 -> bp_o=4'b0100 cycle 11 only, halt_req_o[2]=1 from 12, cause_o[2]=01.
REQ-032 XTRIG_EN, mask=4'b1011, core_bp_i[0] rises -> bp_o=4'b1011 one cycle, causes core0=01, core1=10, core3=10, core2=00, halt_req_o=4'b1011.
REQ-033 stall_i[1]=1 from RUN, core_halted_i[1] after 5 cycles -> HALTED, cause 11; stall_i[1]=0 -> halt_req_o[1]=0 next cycle; core_halted_i[1]=0 -> RUN, cause 00.
REQ-034 Simultaneous core_bp_i[0] and [1] rise, mask=4'b0011, XTRIG_EN -> both causes 01, bp_o=4'b0011 once.
REQ-035 core_bp_i[3] held high through halt/resume -> no second bp_o[3]; drop low then high -> new pulse.
REQ-036 cpu_rstn_i low while core 2 in HALT_WAIT -> all outputs 0 asynchronously, FSM RUN after release.

Source files
------------

// File: rtl/adbg_or1k_bp_xtrig_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adbg_or1k_bp_xtrig_if : breakpoint / halt handshake signal bundle    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface adbg_or1k_bp_xtrig_if #(
    parameter int NB_CORES = 4
);
    logic [NB_CORES-1:0]   core_bp_i;
    logic [NB_CORES-1:0]   core_halted_i;
    logic [NB_CORES-1:0]   stall_i;
    logic [NB_CORES-1:0]   xtrig_mask_i;
    logic [NB_CORES-1:0]   bp_o;
    logic [NB_CORES-1:0]   halt_req_o;
    logic [2*NB_CORES-1:0] cause_o;
    logic                  all_halted_o;

    modport master (
        output core_bp_i, core_halted_i, stall_i, xtrig_mask_i,
        input  bp_o, halt_req_o, cause_o, all_halted_o
    );

    modport slave (
        input  core_bp_i, core_halted_i, stall_i, xtrig_mask_i,
        output bp_o, halt_req_o, cause_o, all_halted_o
    );
endinterface
`default_nettype wire

// File: rtl/adbg_or1k_bp_xtrig.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adbg_or1k_bp_xtrig : per-core breakpoint halt FSMs with cross-trigger|
// | Cross-trigger built only when ADBG_OR1K_XTRIG_EN is defined.         |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module adbg_or1k_bp_xtrig #(
    parameter int NB_CORES = 4
) (
    input  wire logic             cpu_clk_i,
    input  wire logic             cpu_rstn_i,
    adbg_or1k_bp_xtrig_if.slave   bus
);

    localparam logic [1:0] ST_RUN         = 2'd0;
    localparam logic [1:0] ST_HALT_WAIT   = 2'd1;
    localparam logic [1:0] ST_HALTED      = 2'd2;
    localparam logic [1:0] ST_RESUME_WAIT = 2'd3;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_BP    = 2'b01;
    localparam logic [1:0] CAUSE_XTRIG = 2'b10;
    localparam logic [1:0] CAUSE_STALL = 2'b11;

    logic [1:0]            state_q [NB_CORES];
    logic [1:0]            state_d [NB_CORES];
    logic [NB_CORES-1:0]   bp_prev_q;
    logic [NB_CORES-1:0]   bp_q, bp_d;
    logic [NB_CORES-1:0]   halt_req_q, halt_req_d;
    logic [2*NB_CORES-1:0] cause_q, cause_d;
    logic                  all_halted_q, all_halted_d;

    logic [NB_CORES-1:0]   eligible;
    logic [NB_CORES-1:0]   own_evt;
    logic [NB_CORES-1:0]   xtrig_evt;

    // A core already pulsing bp_o is on its way out of RUN and takes no new event.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            eligible[i] = (state_q[i] == ST_RUN) && !bp_q[i];
        end
        own_evt = bus.core_bp_i & ~bp_prev_q & eligible;
    end

`ifdef ADBG_OR1K_XTRIG_EN
    always_comb begin
        xtrig_evt = '0;
        if (|(own_evt & bus.xtrig_mask_i)) begin
            xtrig_evt = bus.xtrig_mask_i & eligible & ~own_evt;
        end
    end
`else
    always_comb begin
        xtrig_evt = '0;
    end
`endif

    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
        if (!cpu_rstn_i) begin
            for (int i = 0; i < NB_CORES; i++) begin
                state_q[i] <= ST_RUN;
            end
        end else begin
            for (int i = 0; i < NB_CORES; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NB_CORES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_RUN:         if (bp_q[i] || bus.stall_i[i])          state_d[i] = ST_HALT_WAIT;
                ST_HALT_WAIT:   if (bus.core_halted_i[i])               state_d[i] = ST_HALTED;
                ST_HALTED:      if (!bus.stall_i[i] && !bp_q[i])        state_d[i] = ST_RESUME_WAIT;
                ST_RESUME_WAIT: if (!bus.core_halted_i[i])              state_d[i] = ST_RUN;
                default:                                                state_d[i] = ST_RUN;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        bp_d         = own_evt | xtrig_evt;
        halt_req_d   = '0;
        cause_d      = cause_q;
        all_halted_d = 1'b1;
        for (int i = 0; i < NB_CORES; i++) begin
            halt_req_d[i] = (state_d[i] == ST_HALT_WAIT) || (state_d[i] == ST_HALTED);
            if (state_d[i] != ST_HALTED) begin
                all_halted_d = 1'b0;
            end
            if (own_evt[i]) begin
                cause_d[2*i +: 2] = CAUSE_BP;
            end else if (xtrig_evt[i]) begin
                cause_d[2*i +: 2] = CAUSE_XTRIG;
            end else if (eligible[i] && bus.stall_i[i]) begin
                cause_d[2*i +: 2] = CAUSE_STALL;
            end else if (state_q[i] == ST_RESUME_WAIT && state_d[i] == ST_RUN) begin
                cause_d[2*i +: 2] = CAUSE_NONE;
            end
        end
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
        if (!cpu_rstn_i) begin
            bp_prev_q    <= '0;
            bp_q         <= '0;
            halt_req_q   <= '0;
            cause_q      <= '0;
            all_halted_q <= 1'b0;
        end else begin
            bp_prev_q    <= bus.core_bp_i;
            bp_q         <= bp_d;
            halt_req_q   <= halt_req_d;
            cause_q      <= cause_d;
            all_halted_q <= all_halted_d;
        end
    end

    assign bus.bp_o         = bp_q;
    assign bus.halt_req_o   = halt_req_q;
    assign bus.cause_o      = cause_q;
    assign bus.all_halted_o = all_halted_q;

endmodule
`default_nettype wire

// File: tb/tb_adbg_or1k_bp_xtrig.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adbg_or1k_bp_xtrig : directed and random checks against a model   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_adbg_or1k_bp_xtrig;

    localparam int NB = 4;
    localparam int M_RUN = 0, M_HWAIT = 1, M_HALTED = 2, M_RWAIT = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    adbg_or1k_bp_xtrig_if #(.NB_CORES(NB)) bus ();

    adbg_or1k_bp_xtrig #(.NB_CORES(NB)) dut (
        .cpu_clk_i  (clk),
        .cpu_rstn_i (rstn),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-core phase, last bp level, pending pulse, cause.
    int       m_st    [NB];
    bit       m_prev  [NB];
    bit       m_pulse [NB];
    bit [1:0] m_cause [NB];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_st[i] = M_RUN; m_prev[i] = 0; m_pulse[i] = 0; m_cause[i] = 2'b00;
        end
    endtask

    task automatic model_step(input logic [NB-1:0] bp, halted, stall, mask);
        bit ready [NB];
        bit own   [NB];
        bit xt    [NB];
        bit group_hit = 0;
        for (int i = 0; i < NB; i++) begin
            ready[i] = (m_st[i] == M_RUN) && !m_pulse[i];
            own[i]   = bp[i] && !m_prev[i] && ready[i];
        end
`ifdef ADBG_OR1K_XTRIG_EN
        for (int k = 0; k < NB; k++) if (own[k] && mask[k]) group_hit = 1;
`endif
        for (int i = 0; i < NB; i++) xt[i] = group_hit && mask[i] && ready[i] && !own[i];
        for (int i = 0; i < NB; i++) begin
            if (own[i])                   m_cause[i] = 2'b01;
            else if (xt[i])               m_cause[i] = 2'b10;
            else if (ready[i] && stall[i]) m_cause[i] = 2'b11;
            if (m_st[i] == M_RUN) begin
                if (m_pulse[i] || stall[i]) m_st[i] = M_HWAIT;
            end else if (m_st[i] == M_HWAIT) begin
                if (halted[i]) m_st[i] = M_HALTED;
            end else if (m_st[i] == M_HALTED) begin
                if (!stall[i] && !m_pulse[i]) m_st[i] = M_RWAIT;
            end else if (!halted[i]) begin
                m_st[i] = M_RUN;
                m_cause[i] = 2'b00;
            end
        end
        for (int i = 0; i < NB; i++) begin
            m_pulse[i] = own[i] || xt[i];
            m_prev[i]  = bp[i];
        end
    endtask

    task automatic check_outputs(input string pfx);
        logic [NB-1:0]   eb, eh;
        logic [2*NB-1:0] ec;
        logic            ea;
        ea = 1'b1;
        for (int i = 0; i < NB; i++) begin
            eb[i] = m_pulse[i];
            eh[i] = (m_st[i] == M_HWAIT) || (m_st[i] == M_HALTED);
            ec[2*i +: 2] = m_cause[i];
            if (m_st[i] != M_HALTED) ea = 1'b0;
        end
        check_val({pfx, ".bp_o"},         32'(bus.bp_o),         32'(eb));
        check_val({pfx, ".halt_req_o"},   32'(bus.halt_req_o),   32'(eh));
        check_val({pfx, ".cause_o"},      32'(bus.cause_o),      32'(ec));
        check_val({pfx, ".all_halted_o"}, 32'(bus.all_halted_o), 32'(ea));
    endtask

    task automatic step(input string pfx, input logic [NB-1:0] bp, halted, stall, mask);
        bus.core_bp_i     = bp;
        bus.core_halted_i = halted;
        bus.stall_i       = stall;
        bus.xtrig_mask_i  = mask;
        @(posedge clk);
        model_step(bp, halted, stall, mask);
        #1;
        check_outputs(pfx);
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        bus.core_bp_i = '0; bus.core_halted_i = '0; bus.stall_i = '0; bus.xtrig_mask_i = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs("reset");
        rstn = 1'b1;
    endtask

    initial begin
        logic [NB-1:0] r_bp, r_halted, r_stall, r_mask;
        int pulses;

        // Own breakpoint on core 2, isolated group.
        reset_dut();
        for (int c = 0; c < 3; c++) step("r031_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("r031", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        check_val("r031_bp_pulse", 32'(bus.bp_o), 32'h4);
        step("r031", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        check_val("r031_bp_gone",  32'(bus.bp_o), 32'h0);
        check_val("r031_halt_req", 32'(bus.halt_req_o), 32'h4);
        check_val("r031_cause",    32'(bus.cause_o[5:4]), 32'h1);
        step("r031", 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        step("r031", 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        step("r031", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        check_val("r031_resumed", 32'(bus.halt_req_o), 32'h0);

        // Cross-trigger group 1011, core 0 fires.
        reset_dut();
        step("r032", 4'b0001, 4'b0000, 4'b0000, 4'b1011);
`ifdef ADBG_OR1K_XTRIG_EN
        check_val("r032_bp",    32'(bus.bp_o),    32'hB);
        check_val("r032_cause", 32'(bus.cause_o), 32'h89);
        step("r032", 4'b0001, 4'b0000, 4'b0000, 4'b1011);
        check_val("r032_halt_req", 32'(bus.halt_req_o), 32'hB);
`else
        check_val("r032_bp",    32'(bus.bp_o),    32'h1);
        check_val("r032_cause", 32'(bus.cause_o), 32'h01);
        step("r032", 4'b0001, 4'b0000, 4'b0000, 4'b1011);
        check_val("r032_halt_req", 32'(bus.halt_req_o), 32'h1);
`endif

        // Simultaneous own events inside one group.
        reset_dut();
        step("r034", 4'b0011, 4'b0000, 4'b0000, 4'b0011);
        check_val("r034_bp",    32'(bus.bp_o),    32'h3);
        check_val("r034_cause", 32'(bus.cause_o), 32'h05);
        step("r034", 4'b0011, 4'b0000, 4'b0000, 4'b0011);
        check_val("r034_once",  32'(bus.bp_o),    32'h0);

        // Host stall on core 1 with a slow halt acknowledge.
        reset_dut();
        for (int c = 0; c < 5; c++) step("r033", 4'b0000, 4'b0000, 4'b0010, 4'b0000);
        check_val("r033_halt_req", 32'(bus.halt_req_o), 32'h2);
        check_val("r033_cause",    32'(bus.cause_o[3:2]), 32'h3);
        step("r033", 4'b0000, 4'b0010, 4'b0010, 4'b0000);
        step("r033", 4'b0000, 4'b0010, 4'b0010, 4'b0000);
        step("r033", 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        check_val("r033_release", 32'(bus.halt_req_o), 32'h0);
        step("r033", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        check_val("r033_cause_clr", 32'(bus.cause_o), 32'h0);

        // Breakpoint level held high across a full halt/resume.
        reset_dut();
        pulses = 0;
        step("r035", 4'b1000, 4'b0000, 4'b0000, 4'b0000); pulses += int'(bus.bp_o[3]);
        step("r035", 4'b1000, 4'b0000, 4'b0000, 4'b0000); pulses += int'(bus.bp_o[3]);
        step("r035", 4'b1000, 4'b1000, 4'b0000, 4'b0000); pulses += int'(bus.bp_o[3]);
        step("r035", 4'b1000, 4'b1000, 4'b0000, 4'b0000); pulses += int'(bus.bp_o[3]);
        for (int c = 0; c < 4; c++) begin
            step("r035", 4'b1000, 4'b0000, 4'b0000, 4'b0000); pulses += int'(bus.bp_o[3]);
        end
        check_val("r035_single", 32'(pulses), 32'd1);
        step("r035", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("r035", 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        check_val("r035_repulse", 32'(bus.bp_o), 32'h8);

        // Asynchronous reset while core 2 waits for its halt acknowledge.
        reset_dut();
        step("r036", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        step("r036", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        check_val("r036_hwait", 32'(bus.halt_req_o), 32'h4);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_outputs("r036_async");
        @(posedge clk);
        #1 rstn = 1'b1;
        step("r036", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        check_val("r036_edge_from_0", 32'(bus.bp_o), 32'h4);

        // Randomized traffic against the model.
        reset_dut();
        r_bp = '0; r_halted = '0; r_stall = '0; r_mask = 4'(($urandom));
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 99) < 30) r_bp[i]     = ~r_bp[i];
                if ($urandom_range(0, 99) < 25) r_halted[i] = ~r_halted[i];
                if ($urandom_range(0, 99) < 8)  r_stall[i]  = ~r_stall[i];
            end
            if (c % 50 == 0) r_mask = 4'($urandom);
            step("rand", r_bp, r_halted, r_stall, r_mask);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
